// File: rtl/pe2_controller_pkg.sv
// rtl/pe2_controller_pkg.sv - shared types and constants for the PE2 controller (PE2_CTRL_PERF_EN adds STALL_W)
package pe2_ctrl_pkg;

    localparam int NUM_PE        = 4;
    localparam int NUM_TAPS      = 16;
    localparam int BEATS_PER_WIN = NUM_PE * NUM_TAPS;
    localparam int BEAT_W        = $clog2(BEATS_PER_WIN);
    localparam int TAP_W         = $clog2(NUM_TAPS);
`ifdef PE2_CTRL_PERF_EN
    localparam int STALL_W       = 16;
`endif

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        CLR,
        MAC,
        WAIT,
        STORE,
        DONE
    } state_e;

    typedef logic [NUM_PE-1:0][NUM_TAPS-1:0] en1_t;

endpackage

// File: rtl/pe2_controller_if.sv
// rtl/pe2_controller_if.sv - CNN-controller/PE2 control bundle (PE2_CTRL_PERF_EN adds stall_cnt)
import pe2_ctrl_pkg::*;

interface pe2_controller_if;
    logic             start;
    logic             busy;
    logic             done;
    logic             load_valid;
    logic             load_ready;
    logic [TAP_W-1:0] sel;
    logic             en0;
    logic             rst0;
    en1_t             en1;
    logic             en2;
    logic             en3;
    logic             rst3;
    logic             cout3;
`ifdef PE2_CTRL_PERF_EN
    logic [STALL_W-1:0] stall_cnt;
`endif

    modport master (
        output start, load_valid, cout3,
        input  busy, done, load_ready, sel, en0, rst0, en1, en2, en3, rst3
`ifdef PE2_CTRL_PERF_EN
        , stall_cnt
`endif
    );

    modport slave (
        input  start, load_valid, cout3,
        output busy, done, load_ready, sel, en0, rst0, en1, en2, en3, rst3
`ifdef PE2_CTRL_PERF_EN
        , stall_cnt
`endif
    );
endinterface

// File: rtl/pe2_controller_load_sequencer.sv
// rtl/pe2_controller_load_sequencer.sv - beat counter and one-hot PE buffer write-enable decoder
module pe2_load_sequencer
    import pe2_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic accept_i,
    output en1_t en1_o,
    output logic last_beat_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;

    assign last_beat_o = (beat_q == BEAT_W'(BEATS_PER_WIN - 1));

    always_comb begin
        beat_d = beat_q;
        if (clear_i) begin
            beat_d = '0;
        end else if (accept_i) begin
            beat_d = last_beat_o ? '0 : beat_q + 1'b1;
        end
    end

    // Upper beat bits pick the PE, lower bits pick the buffer entry.
    always_comb begin
        en1_o = '0;
        if (accept_i) begin
            en1_o[beat_q[BEAT_W-1:TAP_W]][beat_q[TAP_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/pe2_controller.sv
// rtl/pe2_controller.sv - PE2 run sequencer: load, clear, MAC sweep, store per window
// Optional stall counter output enabled by PE2_CTRL_PERF_EN.
module pe2_controller
    import pe2_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    pe2_controller_if.slave ctrl_if
);

    state_e           state_q, state_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic             accept;
    logic             last_beat;
    en1_t             en1;

    assign accept = (state_q == LOAD) && ctrl_if.load_valid;

    pe2_load_sequencer u_load_seq (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (state_q == INIT),
        .accept_i    (accept),
        .en1_o       (en1),
        .last_beat_o (last_beat)
    );

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        case (state_q)
            IDLE:  if (ctrl_if.start) state_d = INIT;
            INIT:  state_d = LOAD;
            LOAD:  if (accept && last_beat) state_d = CLR;
            CLR:   state_d = MAC;
            MAC: begin
                if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = WAIT;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            WAIT:  state_d = STORE;
            // cout3 reflects the count before this cycle's en3 lands.
            STORE: state_d = ctrl_if.cout3 ? DONE : LOAD;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tap_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
        end
    end

    assign ctrl_if.busy       = (state_q != IDLE);
    assign ctrl_if.done       = (state_q == DONE);
    assign ctrl_if.load_ready = (state_q == LOAD);
    assign ctrl_if.rst3       = (state_q == INIT);
    assign ctrl_if.rst0       = (state_q == CLR);
    assign ctrl_if.en0        = (state_q == MAC);
    assign ctrl_if.sel        = (state_q == MAC) ? tap_q : '0;
    assign ctrl_if.en1        = en1;
    assign ctrl_if.en2        = (state_q == STORE);
    assign ctrl_if.en3        = (state_q == STORE);

`ifdef PE2_CTRL_PERF_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == INIT) begin
            stall_d = '0;
        end else if ((state_q == LOAD) && !ctrl_if.load_valid && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign ctrl_if.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe2_controller.sv
// tb/tb_pe2_controller.sv - scoreboard bench for pe2_controller (honours PE2_CTRL_PERF_EN)
module tb_pe2_controller;
    import pe2_ctrl_pkg::*;

    localparam int K_RST3  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_CLR   = 2;
    localparam int K_MAC   = 3;
    localparam int K_STORE = 4;
    localparam int K_DONE  = 5;

    typedef struct {
        int kind;
        int arg;
        int gap;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic load_valid = 1'b0;
    logic force_c3 = 1'b0;
    logic [3:0] c4;

    always #5 clk = ~clk;

    pe2_controller_if tb_if ();
    assign tb_if.start      = start;
    assign tb_if.load_valid = load_valid;

    // Window counter stand-in: cleared by rst3, advanced by en3, flags count 15.
    always @(posedge clk or posedge rst) begin
        if (rst)             c4 <= 4'd0;
        else if (tb_if.rst3) c4 <= 4'd0;
        else if (tb_if.en3)  c4 <= c4 + 4'd1;
    end
    assign tb_if.cout3 = force_c3 | (c4 == 4'd15);

    pe2_controller dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (tb_if)
    );

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  gap = 0;
    int  done_seen = 0, done_cyc = 0, en2_cnt = 0, rst3_cnt = 0, rst3_cyc = 0;
    int  stall_cycles = 0, load_cycles = 0;
    int  mode = 0;
    bit  phase = 1'b0;
    logic [74:0] mv;
    ev_t me;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [74:0] out_vec();
        return {tb_if.rst3, tb_if.en1, tb_if.rst0, tb_if.en0, tb_if.sel,
                tb_if.en2, tb_if.en3, tb_if.done, tb_if.load_ready};
    endfunction

    function automatic logic [74:0] exp_vec(input ev_t e);
        logic [63:0] e1;
        logic [3:0]  s;
        logic        r3, r0, e0, e2, e3, dn, lr;
        e1 = '0;
        s  = '0;
        {r3, r0, e0, e2, e3, dn, lr} = '0;
        case (e.kind)
            K_RST3:  r3 = 1'b1;
            K_LOAD:  begin e1 = 64'd1 << e.arg; lr = 1'b1; end
            K_CLR:   r0 = 1'b1;
            K_MAC:   begin e0 = 1'b1; s = 4'(e.arg); end
            K_STORE: begin e2 = 1'b1; e3 = 1'b1; end
            default: dn = 1'b1;
        endcase
        return {r3, e1, r0, e0, s, e2, e3, dn, lr};
    endfunction

    // Expected activity of one run; gap is idle cycles since the previous event (-1: any).
    task automatic push_run(input int nwin);
        exp_q.push_back('{K_RST3, 0, -1});
        for (int w = 0; w < nwin; w++) begin
            for (int b = 0; b < 64; b++) exp_q.push_back('{K_LOAD, b, -1});
            exp_q.push_back('{K_CLR, 0, 0});
            for (int t = 0; t < 16; t++) exp_q.push_back('{K_MAC, t, 0});
            exp_q.push_back('{K_STORE, 0, 1});
        end
        exp_q.push_back('{K_DONE, 0, 0});
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            load_valid = 1'b0;
            phase      = 1'b0;
        end else begin
            case (mode)
                0: load_valid = 1'b1;
                1: load_valid = 1'($urandom_range(0, 1));
                default: begin
                    if (tb_if.load_ready) begin
                        load_valid = !phase;
                        phase      = !phase;
                    end else begin
                        load_valid = 1'($urandom_range(0, 1));
                        phase      = 1'b0;
                    end
                end
            endcase
            if (tb_if.load_ready) begin
                load_cycles++;
                if (!load_valid) stall_cycles++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            gap = 0;
        end else begin
            mv = out_vec();
            if (mv[74:1] != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 128'(mv), 128'd0);
                end else begin
                    me = exp_q.pop_front();
                    check("event_outputs", 128'(mv), 128'(exp_vec(me)));
                    if (me.gap >= 0) check("event_gap", gap, me.gap);
                    check("busy_during_run", 128'(tb_if.busy), 128'd1);
                    if (tb_if.en1 != '0)
                        check("en1_only_on_accept", 128'(load_valid & tb_if.load_ready), 128'd1);
`ifdef PE2_CTRL_PERF_EN
                    if (tb_if.rst0) check("stall_cnt_at_clr", 128'(tb_if.stall_cnt), stall_cycles);
`endif
                end
                if (tb_if.done) begin done_seen++; done_cyc = cyc; end
                if (tb_if.en2) en2_cnt++;
                if (tb_if.rst3) begin rst3_cnt++; rst3_cyc = cyc; end
                gap = 0;
            end else begin
                gap++;
            end
        end
    end

    task automatic do_run(input int m, input bit fc, input int nwin, input bit poke);
        int s;
        mode = m;
        force_c3 = fc;
        stall_cycles = 0;
        load_cycles = 0;
        done_seen = 0;
        en2_cnt = 0;
        rst3_cnt = 0;
        @(negedge clk);
        push_run(nwin);
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8000 && done_seen == 0; i++) begin
            @(posedge clk);
            #2;
            start = poke && (i == 40);
        end
        start = 1'b0;
        if (done_seen == 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("run_latency", done_cyc - s, 2 + 83 * nwin + stall_cycles);
            check("en2_pulses", en2_cnt, nwin);
            check("rst3_pulses", rst3_cnt, 1);
            check("rst3_after_start", rst3_cyc - s, 1);
            check("done_pulses", done_seen, 1);
            check("queue_drained", exp_q.size(), 0);
            @(negedge clk);
            check("idle_after_done", 128'({tb_if.busy, tb_if.done, tb_if.load_ready}), 128'd0);
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 128'(out_vec()), 128'd0);
        check("reset_busy", 128'(tb_if.busy), 128'd0);
`ifdef PE2_CTRL_PERF_EN
        check("reset_stall_cnt", 128'(tb_if.stall_cnt), 128'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        do_run(0, 1'b0, 16, 1'b0);

        mode = 0;
        force_c3 = 1'b0;
        @(negedge clk);
        push_run(16);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (tb_if.en0 && tb_if.sel == 4'd7) found = 1'b1;
        end
        check("reached_sel7", 128'(found), 128'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_run_reset_outputs", 128'(out_vec()), 128'd0);
        check("mid_run_reset_busy", 128'(tb_if.busy), 128'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_idle", 128'({out_vec(), tb_if.busy}), 128'd0);

        do_run(1, 1'b0, 16, 1'b0);

        do_run(2, 1'b1, 1, 1'b1);
        check("toggle_load_cycles", load_cycles, 127);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
